test_signal_gen: RTL and testbench

TEST_SIGNAL_GEN -- requirements
Module: test_signal_gen

---
 rtl/test_signal_gen.sv | 138 +++++++++++++
 tb/tb_test_signal_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/test_signal_gen.sv
// Configurable square-wave generator with burst/continuous modes,
// graceful stop and a single-entry pending configuration slot.
module test_signal_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_burst,
    input  logic             start,
    input  logic             stop,
    output logic             sig_out,
    output logic             period_strobe,
    output logic             busy,
    output logic             burst_done
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_p;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_bcnt;
    logic [CNT_W-1:0] r_pp;
    logic [CNT_W-1:0] r_ph;
    logic [CNT_W-1:0] r_pn;
    logic             r_pend;
    logic             r_stop;

    logic [CNT_W-1:0] w_cp;
    logic [CNT_W-1:0] w_ch;
    logic             w_acc;
    logic             w_end_per;
    logic             w_last;
    logic             w_stop;

    // Clamp the offered word so the active registers always hold a legal shape
    assign w_cp = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;
    assign w_ch = (cfg_high == '0)  ? CNT_W'(1) :
                  (cfg_high >= w_cp) ? w_cp - CNT_W'(1) : cfg_high;

    assign cfg_ready = ~r_pend;
    assign w_acc     = cfg_valid & cfg_ready;
    assign w_end_per = (r_pcnt == r_p - CNT_W'(1));
    assign w_last    = (r_n != '0) && (r_bcnt == r_n - CNT_W'(1));
    assign w_stop    = r_stop | stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_p           <= CNT_W'(2);
            r_h           <= CNT_W'(1);
            r_n           <= '0;
            r_pcnt        <= '0;
            r_bcnt        <= '0;
            r_pp          <= '0;
            r_ph          <= '0;
            r_pn          <= '0;
            r_pend        <= 1'b0;
            r_stop        <= 1'b0;
            sig_out       <= 1'b0;
            period_strobe <= 1'b0;
            busy          <= 1'b0;
            burst_done    <= 1'b0;
        end else begin
            period_strobe <= 1'b0;
            burst_done    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_p <= w_cp;
                        r_h <= w_ch;
                        r_n <= cfg_burst;
                    end
                    if (start && !stop) begin
                        r_state       <= S_RUN;
                        sig_out       <= 1'b1;
                        period_strobe <= 1'b1;
                        busy          <= 1'b1;
                        r_pcnt        <= '0;
                        r_bcnt        <= '0;
                        r_stop        <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_acc) begin
                        r_pend <= 1'b1;
                        r_pp   <= w_cp;
                        r_ph   <= w_ch;
                        r_pn   <= cfg_burst;
                    end
                    r_stop <= w_stop;
                    if (!w_end_per) begin
                        r_pcnt  <= r_pcnt + CNT_W'(1);
                        sig_out <= (r_pcnt + CNT_W'(1)) < r_h;
                    end else if (w_stop || w_last) begin
                        // Run ends; any waiting word becomes active on IDLE entry
                        r_state    <= S_IDLE;
                        sig_out    <= 1'b0;
                        busy       <= 1'b0;
                        burst_done <= w_last && !w_stop;
                        r_stop     <= 1'b0;
                        r_pend     <= 1'b0;
                        if (w_acc) begin
                            r_p <= w_cp;
                            r_h <= w_ch;
                            r_n <= cfg_burst;
                        end else if (r_pend) begin
                            r_p <= r_pp;
                            r_h <= r_ph;
                            r_n <= r_pn;
                        end
                    end else begin
                        r_pcnt        <= '0;
                        sig_out       <= 1'b1;
                        period_strobe <= 1'b1;
                        if (r_pend) begin
                            r_p    <= r_pp;
                            r_h    <= r_ph;
                            r_n    <= r_pn;
                            r_pend <= 1'b0;
                            r_bcnt <= '0;
                        end else begin
                            r_bcnt <= r_bcnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_signal_gen.sv
// Directed and randomized checks of test_signal_gen against a
// cycle-index waveform model.
module tb_test_signal_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_period;
    logic [15:0] cfg_high;
    logic [15:0] cfg_burst;
    logic        start;
    logic        stop;
    logic        sig_out;
    logic        period_strobe;
    logic        busy;
    logic        burst_done;

    int n_pass  = 0;
    int n_total = 0;

    test_signal_gen #(.CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_period    (cfg_period),
        .cfg_high      (cfg_high),
        .cfg_burst     (cfg_burst),
        .start         (start),
        .stop          (stop),
        .sig_out       (sig_out),
        .period_strobe (period_strobe),
        .busy          (busy),
        .burst_done    (burst_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int cp(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic int ch(input int p, input int h);
        int pp;
        pp = cp(p);
        if (h == 0) return 1;
        if (h >= pp) return pp - 1;
        return h;
    endfunction

    // {sig, strobe, busy, done} at cycle k after start (k=0 is the first busy cycle)
    function automatic logic [3:0] model(input int k, input int p,
                                         input int h, input int n);
        int  total;
        logic act;
        total = n * p;
        act   = (n == 0) || (k < total);
        return {act && ((k % p) < h), act && ((k % p) == 0), act,
                (n != 0) && (k == total)};
    endfunction

    function automatic logic [3:0] obs4();
        return {sig_out, period_strobe, busy, burst_done};
    endfunction

    task automatic do_cfg(input int p, input int h, input int n);
        cfg_valid  = 1'b1;
        cfg_period = 16'(p);
        cfg_high   = 16'(h);
        cfg_burst  = 16'(n);
        step();
        cfg_valid  = 1'b0;
    endtask

    task automatic run_model(input string tag, input int p, input int h,
                             input int n, input int cycles);
        start = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            step();
            start = 1'b0;
            chk($sformatf("%s_k%0d", tag, k), 32'(obs4()),
                32'(model(k, cp(p), ch(p, h), n)));
        end
    endtask

    task automatic stop_idle(input string tag);
        int guard;
        stop = 1'b1;
        step();
        stop = 1'b0;
        guard = 0;
        while (busy && guard < 100) begin
            step();
            guard++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'(0));
        step();
    endtask

    initial begin
        logic [3:0] e;
        int p;
        int h;
        int n;
        rst        = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;
        cfg_burst  = '0;
        start      = 1'b0;
        stop       = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_outs", 32'(obs4()), 32'(0));
        chk("rst_ready", 32'(cfg_ready), 32'(1));
        step();
        rst = 1'b0;
        step();
        chk("post_rst_busy", 32'(busy), 32'(0));

        // Continuous P=10 H=3
        do_cfg(10, 3, 0);
        run_model("cont10", 10, 3, 0, 25);
        stop_idle("cont10");

        // Burst P=4 H=2 N=3 including the burst_done cycle and after
        do_cfg(4, 2, 3);
        run_model("burst", 4, 2, 3, 16);

        // Clamping
        do_cfg(1, 0, 2);
        run_model("clampA", 1, 0, 2, 6);
        do_cfg(5, 7, 1);
        run_model("clampB", 5, 7, 1, 7);

        // Randomized bursts
        for (int i = 0; i < 6; i++) begin
            p = int'($urandom_range(1, 9));
            h = int'($urandom_range(0, 11));
            n = int'($urandom_range(1, 4));
            do_cfg(p, h, n);
            run_model($sformatf("rnd%0d", i), p, h, n, n * cp(p) + 3);
        end

        // Mid-run reconfiguration
        do_cfg(8, 4, 0);
        start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            start     = 1'b0;
            cfg_valid = 1'b0;
            e = (k < 8) ? model(k, 8, 4, 0) : model(k - 8, 6, 1, 0);
            chk($sformatf("recfg_k%0d", k), 32'(obs4()), 32'(e));
            chk($sformatf("recfg_rdy%0d", k), 32'(cfg_ready),
                32'((k >= 3 && k < 8) ? 0 : 1));
            if (k == 2) begin
                cfg_valid  = 1'b1;
                cfg_period = 16'd6;
                cfg_high   = 16'd1;
                cfg_burst  = 16'd0;
            end
        end
        cfg_valid = 1'b0;
        stop_idle("recfg");

        // Graceful stop
        do_cfg(6, 2, 0);
        start = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            start = 1'b0;
            stop  = (k == 1);
            e = (k < 6) ? model(k, 6, 2, 0) : 4'b0000;
            chk($sformatf("stop_k%0d", k), 32'(obs4()), 32'(e));
        end
        stop = 1'b0;

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            start = 1'b0;
            stop  = 1'b0;
            chk($sformatf("ss_k%0d", k), 32'(obs4()), 32'(0));
        end

        // Asynchronous reset during the high phase
        do_cfg(10, 5, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("pre_rst_sig", 32'(sig_out), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("arst_outs", 32'(obs4()), 32'(0));
        chk("arst_ready", 32'(cfg_ready), 32'(1));
        step();
        rst = 1'b0;
        step();
        chk("rel_busy", 32'(busy), 32'(0));
        chk("rel_ready", 32'(cfg_ready), 32'(1));
        run_model("rstcfg", 2, 1, 0, 6);
        stop_idle("rstcfg");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
